// File: rtl/jk_latch_driver.sv
// jk_latch_driver: command stage for a level-sensitive JK latch.
// Accepts hold/reset/set/toggle over valid/ready and drives a J/K setup,
// C pulse and hold sequence. It then samples the latch Q/Qn feedback and
// returns a checked response.
// Toggle is resolved into an explicit set or reset from the Q sampled at
// acceptance, so the latch never sees J=K=1 while C is high.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                00 hold, 01 reset, 10 set, 11 toggle
//   j, k, c               registered latch drives
//   q_fb, qn_fb           latch feedback (synchronous to clk)
//   rsp_valid/rsp_ready   response handshake
//   rsp_q, rsp_err        sampled Q and consistency error
//   err_count             saturating count of erroneous responses
module jk_latch_driver #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       j,
  output logic       k,
  output logic       c,
  input  logic       q_fb,
  input  logic       qn_fb,
  output logic       rsp_valid,
  output logic       rsp_q,
  output logic       rsp_err,
  input  logic       rsp_ready,
  output logic [7:0] err_count
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             expected;
  logic             accept;
  logic             chk_err;

  // Ready is gated by rst so it is low for the whole reset assertion.
  assign cmd_ready = (state == IDLE) & ~rst;
  assign accept    = cmd_valid & cmd_ready;
  assign chk_err   = (q_fb != expected) | (q_fb == qn_fb);

  // Sequencer: all outputs registered, c changes only on clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      expected  <= 1'b0;
      j         <= 1'b0;
      k         <= 1'b0;
      c         <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_q     <= 1'b0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= '0;
            state <= SETUP;
            case (cmd_op)
              2'b00: begin j <= 1'b0;  k <= 1'b0; expected <= q_fb;  end
              2'b01: begin j <= 1'b0;  k <= 1'b1; expected <= 1'b0;  end
              2'b10: begin j <= 1'b1;  k <= 1'b0; expected <= 1'b1;  end
              // toggle becomes set or reset of the opposite of current Q
              default: begin j <= ~q_fb; k <= q_fb; expected <= ~q_fb; end
            endcase
          end
        end
        SETUP: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            c     <= 1'b1;
            state <= PULSE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt == PULSE_LAST) begin
            cnt   <= '0;
            c     <= 1'b0;
            state <= HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            j     <= 1'b0;
            k     <= 1'b0;
            state <= CHECK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          rsp_q     <= q_fb;
          rsp_err   <= chk_err;
          rsp_valid <= 1'b1;
          if (chk_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_latch_driver.sv
// tb_jk_latch_driver: randomized and directed bench for jk_latch_driver.
// A JK latch model feeds q_fb/qn_fb, with injectable faults (both low, or
// stuck at a value). A transaction-level reference predicts all outputs
// from the cycles elapsed since acceptance.
module tb_jk_latch_driver;

  localparam int S   = 1;
  localparam int P   = 2;
  localparam int LAT = 2 + 2 * S + P;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       rsp_ready = 1'b1;
  logic       cmd_ready, j, k, c, rsp_valid, rsp_q, rsp_err;
  logic [7:0] err_count;
  logic       q_fb, qn_fb;

  logic lq = 1'b0;
  int   fault_mode = 0;
  logic stuck = 1'b0;
  bit   chk_en = 1'b0;

  int tests = 0;
  int fails = 0;

  jk_latch_driver #(.SETTLE_CYCLES(S), .PULSE_CYCLES(P)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .j(j), .k(k), .c(c), .q_fb(q_fb), .qn_fb(qn_fb),
    .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Latch feedback with fault injection.
  assign q_fb  = (fault_mode == 1) ? 1'b0 : (fault_mode == 2) ? stuck  : lq;
  assign qn_fb = (fault_mode == 1) ? 1'b0 : (fault_mode == 2) ? ~stuck : ~lq;

  // Same-clock JK latch: transparent while C is high.
  always @(posedge clk) begin
    if (c) begin
      if (j && !k)      lq <= 1'b1;
      else if (k && !j) lq <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one transaction in flight, timed by t (edges since acceptance).
  bit   busy = 1'b0;
  int   t = 0;
  logic m_j = 1'b0, m_k = 1'b0, m_exp = 1'b0, m_rq = 1'b0, m_re = 1'b0;
  int   m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      busy = 1'b0; t = 0; m_j = 1'b0; m_k = 1'b0;
      m_rq = 1'b0; m_re = 1'b0; m_cnt = 0;
    end else if (!busy) begin
      if (cmd_valid) begin
        busy = 1'b1;
        t = 0;
        case (cmd_op)
          2'd0:    m_exp = q_fb;
          2'd1:    m_exp = 1'b0;
          2'd2:    m_exp = 1'b1;
          default: m_exp = ~q_fb;
        endcase
        m_j = (cmd_op != 2'd0) && m_exp;
        m_k = (cmd_op != 2'd0) && !m_exp;
      end
    end else if (t >= LAT - 1) begin
      if (rsp_ready) busy = 1'b0;
    end else begin
      t++;
      if (t == LAT - 1) begin
        m_rq = q_fb;
        m_re = (q_fb !== m_exp) || (q_fb === qn_fb);
        if (m_re && m_cnt < 255) m_cnt++;
      end
    end
  end

  // Per-cycle comparison of every output against the reference.
  always @(negedge clk) begin
    logic e_j, e_k, e_c, e_rv, e_rdy;
    if (chk_en) begin
      e_j   = busy && (t <= 2 * S + P - 1) && m_j;
      e_k   = busy && (t <= 2 * S + P - 1) && m_k;
      e_c   = busy && (t >= S) && (t < S + P);
      e_rv  = busy && (t >= LAT - 1);
      e_rdy = !busy && !rst;
      check("cycle_outputs",
            32'({cmd_ready, j, k, c, rsp_valid, rsp_q, rsp_err, err_count}),
            32'({e_rdy, e_j, e_k, e_c, e_rv, m_rq, m_re, 8'(m_cnt)}));
    end
  end

  task automatic send(input logic [1:0] op);
    @(negedge clk);
    #1 cmd_valid = 1'b1;
    cmd_op = op;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Issue one command; pin first-cycle j/k, pulse width, latency and response.
  task automatic run_op(input logic [1:0] op, input logic ej, input logic ek,
                        input logic eq, input logic ee, input string name);
    int  n;
    int  ccnt;
    bit  got;
    send(op);
    n = 0; ccnt = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) check({name, "_jk"}, 32'({j, k}), 32'({ej, ek}));
      if (c) ccnt++;
      if (rsp_valid) begin got = 1'b1; break; end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no rsp_valid expected within 40 cycles", name);
    end else begin
      check({name, "_latency"}, 32'(n), 32'd6);
      check({name, "_cpulse"}, 32'(ccnt), 32'd2);
      check({name, "_rsp"}, 32'({rsp_q, rsp_err}), 32'({eq, ee}));
    end
  endtask

  initial begin
    bit got;
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({cmd_ready, j, k, c, rsp_valid, rsp_q, rsp_err, err_count}), 32'd0);
    chk_en = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Directed opcodes on a healthy latch (Q starts at 0)
    run_op(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, "set");
    run_op(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, "hold");
    run_op(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, "toggle_from1");
    run_op(2'd3, 1'b1, 1'b0, 1'b1, 1'b0, "toggle_from0");
    run_op(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, "reset_op");

    // Faulty latch: Q and Qn both low
    @(negedge clk);
    #1 fault_mode = 1;
    run_op(2'd2, 1'b1, 1'b0, 1'b0, 1'b1, "faulty");
    check("err_count_one", 32'(err_count), 32'd1);
    for (int i = 1; i < 300; i++) run_op(2'd2, 1'b1, 1'b0, 1'b0, 1'b1, "faulty_rep");
    check("err_count_sat", 32'(err_count), 32'd255);
    @(negedge clk);
    #1 fault_mode = 0;

    // Backpressure: response must hold while rsp_ready is low
    rsp_ready = 1'b0;
    send(2'd2);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL bp_timeout: got no rsp_valid expected within 40 cycles");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_stable", 32'({rsp_valid, rsp_q, rsp_err, cmd_ready}), 32'b1100);
    end
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 32'({rsp_valid, cmd_ready}), 32'b01);

    // Reset mid-pulse: async clear of c/j/k, no response
    send(2'd1);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (c) begin got = 1'b1; break; end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL pulse_timeout: got no c pulse expected within 20 cycles");
    end
    #1 rst = 1'b1;
    #1 check("async_reset", 32'({c, j, k, cmd_ready, rsp_valid}), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    run_op(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, "after_reset");

    // Randomized traffic with faults and reset pulses
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) begin
        fault_mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        stuck      = 1'($urandom_range(0, 1));
      end
    end
    #1 rst = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
